action_input_ctrl: RTL and testbench
====================================

# action_input_ctrl

Front-end stage that feeds the game logic block. It turns raw, asynchronous push-buttons for both players into one one-hot 6-bit action per player per game turn. Each button is synchronised and debounced, and the first press in a turn is latched. At every turn boundary the block presents the latched actions together with a one-cycle `turn_strobe`. The game logic advances state only on cycles where `turn_strobe` is 1.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised cycles required before a button's debounced level changes (≥2).
- `TURN_CYCLES`, 64: clock cycles per game turn (≥4).
- `clock` in 1: single system clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; when 0 at a posedge, all state returns to reset values.
- `btn1` in 5: player 1 raw buttons, asynchronous, active-high; bit order {left, right, jump, punch, kick} = [4:0].
- `btn2` in 5: player 2 raw buttons, same ordering.
- `hold` in 1: freeze, intended to be driven by winner1|winner2; while 1 no turns are issued.
- `player1` out 6: player 1 action, one-hot.
- `player2` out 6: player 2 action, one-hot.
- `turn_strobe` out 1: 1 for exactly one cycle per turn; `player1`/`player2` are valid and new on that cycle.
- `turn_count` out 8: number of turns issued since reset, wraps 255→0.

## Operation
- Action encoding: Wait=100000, Move_Left=010000, Move_Right=001000, Jump=000100, Punch=000010, Kick=000001.
- Synchroniser: per button, 2 flops.
- Debounce: per button, one saturating counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synchronised value differs from the debounced level.
  - It clears to 0 whenever the synchronised value equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event: a rising edge of the debounced level (debounced=1, previous debounced=0). Release events are ignored.
- Pending latch, per player: a `pend_valid` flag plus a 6-bit `pend_action`.
  - The first press event in a turn loads the latch. Later presses in the same turn are ignored.
  - If several press events for one player occur in the same cycle, priority is Punch > Kick > Jump > Move_Left > Move_Right.
- Turn counter: counts 0..TURN_CYCLES-1 and wraps.
  - On the boundary cycle (count==TURN_CYCLES-1), the next edge loads `player1` from its pending action if valid, else Wait. `player2` is loaded the same way.
  - On that edge, `turn_strobe` is set to 1, `turn_count` increments and both pending latches clear.
- Press on the boundary cycle: the latch clears and then takes the new press, so the press belongs to the next turn.
- Outputs hold their value between strobes.
- `hold`=1:
  - Turn counter is forced to 0, pending latches clear, `turn_strobe` is 0, and `player1`/`player2` are forced to Wait.
  - Debounce logic keeps running.
  - After `hold` falls, the first strobe follows TURN_CYCLES cycles later.

## Timing
- Reset values: `player1`=`player2`=100000 (Wait), `turn_strobe`=0, `turn_count`=0.
- Internal reset values: turn counter 0, pending latches empty, synchroniser and debounced levels 0, debounce counters 0.
- Press latency: a raw rise to a registered press event takes 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles.
- Strobe timing: the first strobe asserts on cycle TURN_CYCLES after reset release. Subsequent strobes are exactly TURN_CYCLES cycles apart.
- Action timing: the action appears on the same cycle as its strobe and is registered, with no combinational path from the inputs.
- Reset mid-turn: pending presses are discarded, the counter restarts and outputs return to Wait on the next edge.
- A button held for many turns produces exactly one press event, and therefore exactly one non-Wait action.

## Structure
- The shared package `game_pkg` holds:
  - the six action localparams above, also used by the game logic;
  - the button bit indices;
  - a 6-bit action typedef.
- Sub-module `button_debounce` (synchroniser + debounce counter + rising-edge output, parameter DEBOUNCE_CYCLES), instantiated 10×.
- Top level: per-player priority/latch logic, turn counter, output registers.
- Target size: roughly 200 lines total.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TURN_CYCLES=16.
- Reset held 3 cycles, then idle 40 cycles → strobes at cycles 16 and 32 after release; both actions 100000; `turn_count`=2.
- `btn1`[punch] high for 10 cycles starting at cycle 2 → the strobe at cycle 16 gives `player1`=000010 and `player2`=100000; the strobe at cycle 32 gives `player1`=100000.
- `btn2` kick and left rising in the same cycle → `player2`=000001. A separate test raises left and then, 3 cycles after its press event, kick → `player2`=010000.
- 3-cycle glitch on `btn1`[jump] → no press event; next `player1`=Wait.
- Press event landing exactly on the boundary cycle → the current strobe shows Wait and the following strobe shows the action.
- `hold`=1 mid-turn with a pending Move_Right → no strobe while `hold`=1 and outputs are Wait; after `hold`=0, the first strobe comes 16 cycles later carrying Wait.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions between the input front-end and the game logic:
// one-hot action codes, raw button bit positions and the press-to-action priority.
package game_pkg;

  typedef logic [5:0] action_t;

  localparam action_t ACT_WAIT  = 6'b100000;
  localparam action_t ACT_LEFT  = 6'b010000;
  localparam action_t ACT_RIGHT = 6'b001000;
  localparam action_t ACT_JUMP  = 6'b000100;
  localparam action_t ACT_PUNCH = 6'b000010;
  localparam action_t ACT_KICK  = 6'b000001;

  localparam logic [2:0] BTN_LEFT  = 3'd4;
  localparam logic [2:0] BTN_RIGHT = 3'd3;
  localparam logic [2:0] BTN_JUMP  = 3'd2;
  localparam logic [2:0] BTN_PUNCH = 3'd1;
  localparam logic [2:0] BTN_KICK  = 3'd0;

  // Simultaneous presses resolve as Punch > Kick > Jump > Left > Right.
  function automatic action_t press_to_action(input logic [4:0] press);
    action_t act;
    if (press[BTN_PUNCH])      act = ACT_PUNCH;
    else if (press[BTN_KICK])  act = ACT_KICK;
    else if (press[BTN_JUMP])  act = ACT_JUMP;
    else if (press[BTN_LEFT])  act = ACT_LEFT;
    else if (press[BTN_RIGHT]) act = ACT_RIGHT;
    else                       act = ACT_WAIT;
    return act;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchroniser, saturating stability counter and
// rising-edge detect on the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, then toggle the level only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      sync1_r   <= btn;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= ~level_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign press = level_r & ~level_d_r;

endmodule

// File: rtl/action_input_ctrl.sv
// Per-player first-press latch and turn sequencer: emits one registered
// one-hot action per player together with a single-cycle turn strobe.
module action_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TURN_CYCLES     = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] btn1,
  input  logic [4:0] btn2,
  input  logic       hold,
  output logic [5:0] player1,
  output logic [5:0] player2,
  output logic       turn_strobe,
  output logic [7:0] turn_count
);

  localparam int TW = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic [4:0]    press1_s;
  logic [4:0]    press2_s;
  logic [TW-1:0] tick_r;
  logic          boundary_s;
  logic          pend1_valid_r, pend2_valid_r;
  action_t       pend1_r, pend2_r;
  logic          pend1_valid_s, pend2_valid_s;
  action_t       pend1_s, pend2_s;

  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
      .clock(clock), .reset(reset), .btn(btn1[i]), .press(press1_s[i])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
      .clock(clock), .reset(reset), .btn(btn2[i]), .press(press2_s[i])
    );
  end

  // A press on the boundary cycle reloads the just-cleared latch, so it belongs to the next turn.
  always_comb begin
    boundary_s    = (tick_r == TURN_LAST);
    pend1_valid_s = pend1_valid_r;
    pend1_s       = pend1_r;
    pend2_valid_s = pend2_valid_r;
    pend2_s       = pend2_r;
    if (hold) begin
      pend1_valid_s = 1'b0;
      pend1_s       = ACT_WAIT;
      pend2_valid_s = 1'b0;
      pend2_s       = ACT_WAIT;
    end else begin
      if (boundary_s || !pend1_valid_r) begin
        pend1_valid_s = |press1_s;
        pend1_s       = press_to_action(press1_s);
      end else begin
        pend1_valid_s = pend1_valid_r;
      end
      if (boundary_s || !pend2_valid_r) begin
        pend2_valid_s = |press2_s;
        pend2_s       = press_to_action(press2_s);
      end else begin
        pend2_valid_s = pend2_valid_r;
      end
    end
  end

  // Turn counter, pending latches and the registered action outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_r        <= '0;
      pend1_valid_r <= 1'b0;
      pend2_valid_r <= 1'b0;
      pend1_r       <= ACT_WAIT;
      pend2_r       <= ACT_WAIT;
      player1       <= ACT_WAIT;
      player2       <= ACT_WAIT;
      turn_strobe   <= 1'b0;
      turn_count    <= 8'd0;
    end else begin
      pend1_valid_r <= pend1_valid_s;
      pend2_valid_r <= pend2_valid_s;
      pend1_r       <= pend1_s;
      pend2_r       <= pend2_s;
      if (hold) begin
        tick_r      <= '0;
        turn_strobe <= 1'b0;
        player1     <= ACT_WAIT;
        player2     <= ACT_WAIT;
      end else if (boundary_s) begin
        tick_r      <= '0;
        turn_strobe <= 1'b1;
        player1     <= pend1_valid_r ? pend1_r : ACT_WAIT;
        player2     <= pend2_valid_r ? pend2_r : ACT_WAIT;
        turn_count  <= turn_count + 8'd1;
      end else begin
        tick_r      <= tick_r + TICK_ONE;
        turn_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_action_input_ctrl.sv
// Bench for action_input_ctrl: per-turn stimulus table plus hand-written
// sequences; expected actions are queued per turn and compared on each strobe.
module tb_action_input_ctrl;
  import game_pkg::*;

  localparam int DEB  = 4;
  localparam int TURN = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hold  = 1'b0;
  logic [4:0] btn1  = 5'd0;
  logic [4:0] btn2  = 5'd0;
  logic [5:0] player1, player2;
  logic       turn_strobe;
  logic [7:0] turn_count;

  always #5 clock = ~clock;

  action_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .TURN_CYCLES(TURN)) dut (
    .clock(clock), .reset(reset), .btn1(btn1), .btn2(btn2), .hold(hold),
    .player1(player1), .player2(player2), .turn_strobe(turn_strobe), .turn_count(turn_count)
  );

  typedef struct {
    logic [5:0] p1;
    logic [5:0] p2;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [4:0] m1;
    logic [4:0] m2;
    int         start;
    int         dur;
    logic [5:0] e1;
    logic [5:0] e2;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[9];
  int         checks = 0;
  int         passes = 0;
  logic       strobe_due = 1'b0;
  logic [7:0] exp_count = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic expect_turn(input logic [5:0] e1, input logic [5:0] e2);
    exp_t e;
    exp_count = exp_count + 8'd1;
    e.p1 = e1;
    e.p2 = e2;
    e.cnt = exp_count;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    strobe_due = 1'b0;
  endtask

  // One full turn; buttons high for j in [s, s+d), strobe expected after the last edge.
  task automatic run_turn(input logic [4:0] m1, input logic [4:0] m2, input int s, input int d);
    for (int j = 1; j <= TURN; j++) begin
      step();
      btn1 = (j >= s && j < s + d) ? m1 : 5'd0;
      btn2 = (j >= s && j < s + d) ? m2 : 5'd0;
      if (j == TURN) strobe_due = 1'b1;
    end
  endtask

  // Scoreboard side: strobe must appear exactly when due and carry the queued actions.
  always @(negedge clock) begin
    if (reset) begin
      if (turn_strobe || strobe_due) check("strobe_timing", {31'd0, turn_strobe}, {31'd0, strobe_due});
      if (turn_strobe && sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("player1", {26'd0, player1}, {26'd0, e.p1});
        check("player2", {26'd0, player2}, {26'd0, e.p2});
        check("turn_count", {24'd0, turn_count}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    vecs[0] = '{5'b00000, 5'b00000, 0, 0,  ACT_WAIT,  ACT_WAIT};
    vecs[1] = '{5'b00000, 5'b00000, 0, 0,  ACT_WAIT,  ACT_WAIT};
    vecs[2] = '{5'b00010, 5'b00000, 2, 10, ACT_PUNCH, ACT_WAIT};
    vecs[3] = '{5'b00000, 5'b00000, 0, 0,  ACT_WAIT,  ACT_WAIT};
    vecs[4] = '{5'b00000, 5'b10001, 1, 8,  ACT_WAIT,  ACT_KICK};
    vecs[5] = '{5'b00100, 5'b00000, 2, 3,  ACT_WAIT,  ACT_WAIT};
    vecs[6] = '{5'b01000, 5'b00100, 3, 8,  ACT_RIGHT, ACT_JUMP};
    vecs[7] = '{5'b00001, 5'b00000, 9, 6,  ACT_WAIT,  ACT_WAIT};
    vecs[8] = '{5'b00000, 5'b00000, 0, 0,  ACT_KICK,  ACT_WAIT};

    repeat (3) @(posedge clock);
    #1;
    check("reset_player1", {26'd0, player1}, {26'd0, ACT_WAIT});
    check("reset_player2", {26'd0, player2}, {26'd0, ACT_WAIT});
    check("reset_strobe", {31'd0, turn_strobe}, 32'd0);
    check("reset_count", {24'd0, turn_count}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      expect_turn(vecs[i].e1, vecs[i].e2);
      run_turn(vecs[i].m1, vecs[i].m2, vecs[i].start, vecs[i].dur);
    end

    // Left first, kick pressed three cycles after left's press event: left wins.
    expect_turn(ACT_WAIT, ACT_LEFT);
    for (int j = 1; j <= TURN; j++) begin
      step();
      btn2 = {(j < 13), 3'b000, (j >= 4 && j < 13)};
      if (j == TURN) strobe_due = 1'b1;
    end

    // Hold mid-turn with a pending Move_Right.
    for (int j = 1; j <= 10; j++) begin
      step();
      btn1 = (j < 9) ? 5'b01000 : 5'd0;
      if (j == 10) hold = 1'b1;
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 3 || k == 15) begin
        check("hold_player1", {26'd0, player1}, {26'd0, ACT_WAIT});
        check("hold_player2", {26'd0, player2}, {26'd0, ACT_WAIT});
        check("hold_count", {24'd0, turn_count}, {24'd0, exp_count});
      end
    end
    hold = 1'b0;
    expect_turn(ACT_WAIT, ACT_WAIT);
    run_turn(5'd0, 5'd0, 0, 0);

    // Jump held across three turns yields one action only.
    expect_turn(ACT_JUMP, ACT_WAIT);
    run_turn(5'b00100, 5'd0, 1, 100);
    expect_turn(ACT_WAIT, ACT_WAIT);
    run_turn(5'b00100, 5'd0, 1, 100);
    expect_turn(ACT_WAIT, ACT_WAIT);
    run_turn(5'b00100, 5'd0, 1, 100);
    expect_turn(ACT_WAIT, ACT_WAIT);
    run_turn(5'd0, 5'd0, 0, 0);

    // Reset mid-turn discards a pending punch and restarts the turn timing.
    expect_turn(ACT_PUNCH, ACT_WAIT);
    run_turn(5'b00010, 5'd0, 1, 6);
    for (int j = 1; j <= 10; j++) begin
      step();
      btn1 = (j < 9) ? 5'b00010 : 5'd0;
      if (j == 10) reset = 1'b0;
    end
    step();
    step();
    check("midreset_player1", {26'd0, player1}, {26'd0, ACT_WAIT});
    check("midreset_player2", {26'd0, player2}, {26'd0, ACT_WAIT});
    check("midreset_count", {24'd0, turn_count}, 32'd0);
    check("midreset_strobe", {31'd0, turn_strobe}, 32'd0);
    reset = 1'b1;
    exp_count = 8'd0;
    expect_turn(ACT_WAIT, ACT_WAIT);
    run_turn(5'd0, 5'd0, 0, 0);

    step();
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
